// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_ENC = 32'h0000_0013;
   localparam logic [31:0] PC_INC  = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a response that arrives while decode is stalled.
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        full
);

   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic        full_reg;

   // Clear wins over load so a redirect in the same cycle leaves the entry empty.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         full_reg  <= 1'b0;
         instr_reg <= NOP_ENC;
         pc_reg    <= '0;
      end else if (load) begin
         full_reg  <= 1'b1;
         instr_reg <= load_instr;
         pc_reg    <= load_pc;
      end else if (drain) begin
         full_reg  <= 1'b0;
      end
   end

   assign instr = instr_reg;
   assign pc    = pc_reg;
   assign full  = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to imem over a single-outstanding
// req/gnt/rvalid handshake and feeds registered instr/pc/valid to decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid
);

   fetch_state_e state_reg, state_next;
   logic [31:0]  fetch_pc_reg, fetch_pc_next;
   logic [31:0]  req_pc_reg, req_pc_next;
   logic         drop_reg, drop_next;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  pc_reg, pc_next;
   logic         valid_reg, valid_next;

   logic         skid_load, skid_drain, skid_clear, skid_full;
   logic [31:0]  skid_instr, skid_pc;
   logic         accept, granted;

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .drain      (skid_drain),
      .clear      (skid_clear),
      .load_instr (imem_rdata),
      .load_pc    (req_pc_reg),
      .instr      (skid_instr),
      .pc         (skid_pc),
      .full       (skid_full)
   );

   assign accept = (state_reg == WAIT) && imem_rvalid && !drop_reg;

   // Back-to-back issue: in WAIT the next request goes out in the same cycle the
   // response is accepted, which sustains one instruction per cycle.
   always_comb begin
      imem_req = 1'b0;
      case (state_reg)
         REQ:     imem_req = 1'b1;
         WAIT:    imem_req = accept && !stall && !redirect_valid;
         default: imem_req = 1'b0;
      endcase
   end

   assign imem_addr = fetch_pc_reg;
   assign granted   = imem_req && imem_gnt;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_pc_next   = req_pc_reg;
      drop_next     = drop_reg;
      instr_next    = instr_reg;
      pc_next       = pc_reg;
      valid_next    = valid_reg;
      skid_load     = 1'b0;
      skid_drain    = 1'b0;
      skid_clear    = 1'b0;

      // Bubble unless something below loads the output registers.
      if (!stall) begin
         instr_next = NOP_INSTR;
         valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            if (granted) begin
               req_pc_next   = fetch_pc_reg;
               fetch_pc_next = fetch_pc_reg + PC_INC;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (drop_reg) begin
                  drop_next  = 1'b0;
                  state_next = REQ;
               end else if (!stall) begin
                  instr_next = imem_rdata;
                  pc_next    = req_pc_reg;
                  valid_next = 1'b1;
                  if (granted) begin
                     req_pc_next   = fetch_pc_reg;
                     fetch_pc_next = fetch_pc_reg + PC_INC;
                     state_next    = WAIT;
                  end else begin
                     state_next = REQ;
                  end
               end else begin
                  skid_load  = 1'b1;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               instr_next = skid_instr;
               pc_next    = skid_pc;
               valid_next = skid_full;
               skid_drain = 1'b1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      // A redirect overrides everything, including stall. Any response still in
      // flight belongs to the old path and must be dropped when it arrives.
      if (redirect_valid) begin
         fetch_pc_next = align_word(redirect_pc);
         instr_next    = NOP_INSTR;
         valid_next    = 1'b0;
         skid_load     = 1'b0;
         skid_drain    = 1'b0;
         skid_clear    = 1'b1;
         if (((state_reg == WAIT) && !imem_rvalid) || granted) begin
            drop_next  = 1'b1;
            state_next = WAIT;
         end else begin
            drop_next  = 1'b0;
            state_next = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= RESET_PC;
         drop_reg     <= 1'b0;
         instr_reg    <= NOP_INSTR;
         pc_reg       <= RESET_PC;
         valid_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         req_pc_reg   <= req_pc_next;
         drop_reg     <= drop_next;
         instr_reg    <= instr_next;
         pc_reg       <= pc_next;
         valid_reg    <= valid_next;
      end
   end

   assign instr       = instr_reg;
   assign pc          = pc_reg;
   assign instr_valid = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural single-outstanding imem model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;

   int checks = 0;
   int errors = 0;

   // Memory model state
   logic        gnt_en = 1'b1;
   int          lat = 1;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_cnt = 0;
   logic [31:0] glog[$];

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr          (instr),
      .pc             (pc),
      .instr_valid    (instr_valid)
   );

   always #5 clk = ~clk;

   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
   end

   // Responses are updated on the falling edge; grant is decided 1 time unit later
   // so it sees imem_req after its combinational dependence on rvalid settles.
   always @(negedge clk) begin
      if (pend && pend_cnt == 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend_addr ^ 32'hA5A5_0000;
         pend        = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         if (pend) pend_cnt = pend_cnt - 1;
      end
      #1;
      imem_gnt = gnt_en && imem_req;
      if (imem_gnt) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = lat;
         glog.push_back(imem_addr);
         $display("imem grant addr=%h latency=%0d", imem_addr, lat);
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      lat = 1;
      repeat (4) step;
      glog.delete();
   endtask

   task automatic test_reset;
      do_reset;
      checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h expected %h", instr, 32'h13); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", instr_valid); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", imem_req); end
   endtask

   task automatic test_stream;
      logic [31:0] a;
      do_reset;
      rst = 1'b0;
      step;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
      step;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_bubble got %b expected 0", instr_valid); end
      for (int i = 0; i < 4; i++) begin
         step;
         a = 32'(i * 4);
         checks++;
         if (instr_valid !== 1'b1 || pc !== a || instr !== (a ^ 32'hA5A5_0000)) begin
            errors++;
            $display("FAIL stream_out%0d got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, instr_valid, pc, instr, a, a ^ 32'hA5A5_0000);
         end
      end
      for (int i = 0; i < 4; i++) begin
         a = 32'(i * 4);
         checks++;
         if (glog.size() <= i || glog[i] !== a) begin errors++; $display("FAIL stream_addr%0d got %h expected %h", i, (glog.size() > i) ? glog[i] : 32'hx, a); end
      end
   endtask

   task automatic test_stall;
      do_reset;
      rst = 1'b0;
      repeat (4) step;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== 32'hA5A5_0004 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got v=%b pc=%h instr=%h req=%b expected v=1 pc=4 instr=a5a50004 req=0", i, instr_valid, pc, instr, imem_req);
         end
      end
      stall = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_noreq got %b expected 0", imem_req); end
      step;
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h8 || instr !== 32'hA5A5_0008) begin
         errors++;
         $display("FAIL stall_drain got v=%b pc=%h instr=%h expected v=1 pc=8 instr=a5a50008", instr_valid, pc, instr);
      end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next_req got req=%b addr=%h expected req=1 addr=c", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_drop;
      bit seen;
      do_reset;
      rst = 1'b0;
      repeat (5) step;
      lat = 3;
      step;
      checks++; if (instr_valid !== 1'b1 || pc !== 32'hC) begin errors++; $display("FAIL redir_pre got v=%b pc=%h expected v=1 pc=c", instr_valid, pc); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      step;
      redirect_valid = 1'b0;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin errors++; $display("FAIL redir_nop got v=%b instr=%h expected v=0 instr=13", instr_valid, instr); end
      step;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_wait got %b expected 0", instr_valid); end
      step;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_dropped got v=%b pc=%h expected v=0", instr_valid, pc); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_req got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
      lat = 1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step;
         if (instr_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || pc !== 32'h100 || instr !== 32'hA5A5_0100) begin
         errors++;
         $display("FAIL redir_first_valid got seen=%b pc=%h instr=%h expected seen=1 pc=100 instr=a5a50100", seen, pc, instr);
      end
      checks++; if (glog.size() < 6 || glog[5] !== 32'h100) begin errors++; $display("FAIL redir_glog got %h expected 100", (glog.size() > 5) ? glog[5] : 32'hx); end
   endtask

   task automatic test_redirect_skid;
      do_reset;
      rst = 1'b0;
      repeat (4) step;
      stall = 1'b1;
      step;
      checks++; if (instr_valid !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL rskid_hold got v=%b pc=%h expected v=1 pc=4", instr_valid, pc); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      step;
      redirect_valid = 1'b0;
      stall = 1'b0;
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin errors++; $display("FAIL rskid_nop got v=%b instr=%h expected v=0 instr=13", instr_valid, instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rskid_req got req=%b addr=%h expected req=1 addr=200", imem_req, imem_addr); end
      step;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rskid_cleared got v=%b pc=%h expected v=0", instr_valid, pc); end
      step;
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h200 || instr !== 32'hA5A5_0200) begin
         errors++;
         $display("FAIL rskid_out got v=%b pc=%h instr=%h expected v=1 pc=200 instr=a5a50200", instr_valid, pc, instr);
      end
   endtask

   task automatic test_wrap;
      do_reset;
      rst = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step;
      redirect_valid = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
      step;
      step;
      checks++; if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || instr !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_out0 got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=5a5afffc", instr_valid, pc, instr); end
      step;
      checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_out1 got v=%b pc=%h instr=%h expected v=1 pc=0 instr=a5a50000", instr_valid, pc, instr); end
      checks++; if (glog.size() < 2 || glog[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h expected 0", (glog.size() > 1) ? glog[1] : 32'hx); end
   endtask

   task automatic test_reset_midop;
      bit seen;
      do_reset;
      lat = 3;
      rst = 1'b0;
      repeat (3) step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      glog.delete();
      checks++; if (instr !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL midrst_state got instr=%h v=%b req=%b expected instr=13 v=0 req=0", instr, instr_valid, imem_req); end
      step;
      checks++; if (instr !== 32'h13 || instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_ignored got instr=%h v=%b expected instr=13 v=0", instr, instr_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_req got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
      lat = 1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step;
         if (instr_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen || pc !== 32'h0 || instr !== 32'hA5A5_0000) begin errors++; $display("FAIL midrst_first got seen=%b pc=%h instr=%h expected seen=1 pc=0 instr=a5a50000", seen, pc, instr); end
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      test_reset;
      test_stream;
      test_stall;
      test_redirect_drop;
      test_redirect_skid;
      test_wrap;
      test_reset_midop;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage and drives its 32-bit instr input, plus the matching PC and a valid flag.
- Owns the fetch PC and issues requests to instruction memory over a single-outstanding req/gnt/rvalid handshake.
- Honours the pipeline stall and branch/jump redirects from execute.
- Discards stale responses after a redirect, and buffers one response that arrives while the pipeline is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP_INSTR, 32'h0000_0013, encoding driven on instr during bubbles (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold output registers (same stall as decode)
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target
- imem_req  out  1  memory request
- imem_addr  out  32  request address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- instr  out  32  registered instruction to decode
- pc  out  32  registered PC of instr
- instr_valid  out  1  instr is a real fetched instruction (0 = bubble)

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. All of the following take effect on the first clk edge with rst high:
  - instr=NOP_INSTR, pc=RESET_PC, instr_valid=0.
  - fetch_pc=RESET_PC, state=IDLE, drop=0, skid empty.
  - imem_req=0 while in IDLE.
- Reset mid-operation has the same effect. imem_rvalid is ignored in IDLE.
- State machine:
  - IDLE: the cycle after reset; go to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_gnt go to WAIT and set fetch_pc=fetch_pc+4 (wraps modulo 2^32).
  - WAIT: waits for imem_rvalid. Response latency is arbitrary, at least 1 cycle after gnt.
  - HOLD: skid buffer full; no request issued. When stall=0, go to REQ.
- Response acceptance (WAIT, imem_rvalid=1, drop=0):
  - stall=0: the output registers load {imem_rdata, addr of that request, 1}. In the same cycle imem_req=1 for the next PC (combinational on imem_rvalid), allowing 1 instr/cycle when gnt is always high. Next state is WAIT on gnt, else REQ.
  - stall=1: the response goes into the 1-entry skid (data+pc); go to HOLD.
- Response with drop=1: discarded, drop cleared, go to REQ. The output is not touched.
- Stall with no response: instr/pc/instr_valid hold. A request may still be issued in REQ.
- Skid drain: on the first cycle with stall=0, the skid contents move to the output registers and the skid empties. The skid has priority over any new response; no request is outstanding in HOLD, so the two cannot collide.
- Bubble: when stall=0 and nothing is loaded this cycle, the outputs become NOP_INSTR, instr_valid=0, pc unchanged.
- Redirect (redirect_valid=1) has highest priority, over stall included:
  - fetch_pc={redirect_pc[31:2],2'b00} (low bits are forced to zero).
  - Outputs become NOP/valid 0; skid is cleared.
  - If a request is outstanding (WAIT, or gnt in this same cycle), set drop=1 and go to WAIT; otherwise go to REQ.
  - In REQ without gnt, imem_addr follows the new PC from the next cycle. Memory samples the address only on gnt.
- Latency: imem_rvalid in cycle T makes instr/instr_valid visible in T+1.
- imem_addr must be stable between req assertion and gnt, except on redirect.

Decomposition:
- Package fetch_pkg: typedef fetch_state_e {IDLE,REQ,WAIT,HOLD}; NOP encoding constant 32'h0000_0013; PC_INC=4.
- A natural sub-module is fetch_skid_buffer, a 1-entry data+pc register with full flag, load, drain and clear.
- Everything else stays in fetch_stage.

Test Plan:
- Reset then gnt=1, 1-cycle rvalid latency, rdata=addr^32'hA5A5_0000 -> addresses 0,4,8,C on consecutive cycles; instr_valid=1 every cycle from the 3rd cycle after reset deassert; pc matches address.
- stall=1 for 3 cycles while response for addr 0x8 arrives -> outputs hold the 0x4 instr; no imem_req during HOLD; 0x8 instr appears the cycle after stall falls; next request is 0xC.
- Redirect to 0x100 while the request for 0x10 is outstanding with 3-cycle latency -> 0x10 response dropped (instr_valid stays 0); next request addr 0x100; first valid output pc=0x100.
- Redirect with redirect_pc=0x203 during stall with a full skid -> skid cleared, output NOP/valid 0, next request addr 0x200.
- fetch_pc=0xFFFF_FFFC granted -> next request addr 0x0000_0000.
- rst asserted in WAIT, rvalid arrives the cycle after -> response ignored; first request addr=RESET_PC; instr=0x13, instr_valid=0 until then.
